// File: rtl/carrier_acq_pkg.sv
// carrier_acq_pkg
// Shared types and defaults for the carrier acquisition sequencer.
//   acq_state_e : sequencer state, encoding is visible on acqState
//   CNT_W_DEF   : default dwell/timeout counter width
//   RETRY_W_DEF : default reacquisition counter width
//   GAIN_W      : width of the lead/lag gain exponents
package carrier_acq_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned RETRY_W_DEF = 8;
  localparam int unsigned GAIN_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_SWEEP    = 3'd2,
    ST_PULLIN   = 3'd3,
    ST_TRACK    = 3'd4,
    ST_HOLDOVER = 3'd5
  } acq_state_e;

  // TRACK and HOLDOVER run the loop with narrow gains and report lock.
  function automatic logic is_locked_state(acq_state_e s);
    return (s == ST_TRACK) || (s == ST_HOLDOVER);
  endfunction

endpackage

// File: rtl/acq_dwell_counter.sv
// acq_dwell_counter
// Saturating dwell counter used to time SWEEP, PULLIN and HOLDOVER.
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : zero the count (wins over increment)
//   inc_i        : increment request, only honoured with sample_en_i
//   sample_en_i  : loop-filter sample strobe
//   limit_i      : comparison limit
//   cnt_o        : current count
//   match_o      : count equals limit_i - 1 (limit 0 handled by the parent)
module acq_dwell_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             sample_en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] limit_m1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && sample_en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_m1 = limit_i - CNT_W'(1);
  assign match_o  = (cnt_q == limit_m1);
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/carrier_acq_sequencer.sv
// carrier_acq_sequencer
// Sequences the carrier loop filter through CLEAR, SWEEP, PULLIN, TRACK and
// HOLDOVER, selecting gain exponents, sweep enable and accumulator clear.
//   clk, reset                   : clock, synchronous active-high reset
//   acqEnable                    : level enable, low forces IDLE
//   sampleEn                     : sample strobe qualifying counts and lock
//   carrierLock                  : loop lock indication
//   wideLeadExp/wideLagExp       : gains for IDLE..PULLIN
//   narrowLeadExp/narrowLagExp   : gains for TRACK/HOLDOVER
//   sweepTimeout                 : SWEEP sample limit, 0 = unlimited
//   settleCount                  : locked PULLIN samples before TRACK
//   holdTimeout                  : unlocked HOLDOVER samples before restart
//   leadExp/lagExp               : selected gains (registered)
//   sweepEnable, clearAccum      : loop-filter controls (registered)
//   acqLock                      : high in TRACK/HOLDOVER (registered)
//   acqState                     : current state encoding
//   retryCount                   : saturating restart count
module carrier_acq_sequencer
  import carrier_acq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned RETRY_W = RETRY_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acqEnable,
  input  logic               sampleEn,
  input  logic               carrierLock,
  input  logic [GAIN_W-1:0]  wideLeadExp,
  input  logic [GAIN_W-1:0]  wideLagExp,
  input  logic [GAIN_W-1:0]  narrowLeadExp,
  input  logic [GAIN_W-1:0]  narrowLagExp,
  input  logic [CNT_W-1:0]   sweepTimeout,
  input  logic [CNT_W-1:0]   settleCount,
  input  logic [CNT_W-1:0]   holdTimeout,
  output logic [GAIN_W-1:0]  leadExp,
  output logic [GAIN_W-1:0]  lagExp,
  output logic               sweepEnable,
  output logic               clearAccum,
  output logic               acqLock,
  output logic [2:0]         acqState,
  output logic [RETRY_W-1:0] retryCount
);

  acq_state_e         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_sat;
  logic               cnt_clr, cnt_inc;
  logic [CNT_W-1:0]   dwell_limit;
  logic [CNT_W-1:0]   dwell_cnt;
  logic               dwell_match;
  logic [CNT_W:0]     dwell_p1;
  logic               settle_done;

  logic [GAIN_W-1:0]  lead_d, lag_d, lead_q, lag_q;
  logic               sweep_d, clear_d, lock_d;
  logic               sweep_q, clear_q, lock_q;

  // Only the comparison relevant to the current state uses the limit.
  always_comb begin
    dwell_limit = settleCount;
    unique case (state_q)
      ST_SWEEP:    dwell_limit = sweepTimeout;
      ST_HOLDOVER: dwell_limit = holdTimeout;
      default:     dwell_limit = settleCount;
    endcase
  end

  acq_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .sample_en_i (sampleEn),
    .limit_i     (dwell_limit),
    .cnt_o       (dwell_cnt),
    .match_o     (dwell_match)
  );

  // dwell >= settle-1 evaluated as dwell+1 >= settle one bit wider.
  assign dwell_p1    = {1'b0, dwell_cnt} + (CNT_W+1)'(1);
  assign settle_done = (settleCount == '0) || (dwell_p1 >= {1'b0, settleCount});
  assign retry_sat   = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (!acqEnable) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CLEAR;
          retry_d = '0;
          cnt_clr = 1'b1;
        end
        ST_CLEAR: begin
          state_d = ST_SWEEP;
          cnt_clr = 1'b1;
        end
        ST_SWEEP: begin
          if (sampleEn) begin
            if (carrierLock) begin
              state_d = ST_PULLIN;
              cnt_clr = 1'b1;
            end else if ((sweepTimeout != '0) && dwell_match) begin
              state_d = ST_CLEAR;
              retry_d = retry_sat;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_PULLIN: begin
          if (sampleEn) begin
            if (!carrierLock) begin
              state_d = ST_SWEEP;
              cnt_clr = 1'b1;
            end else if (settle_done) begin
              state_d = ST_TRACK;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (sampleEn && !carrierLock) begin
            state_d = ST_HOLDOVER;
            cnt_clr = 1'b1;
          end
        end
        ST_HOLDOVER: begin
          if (sampleEn) begin
            if (carrierLock) begin
              state_d = ST_TRACK;
              cnt_clr = 1'b1;
            end else if ((holdTimeout == '0) || dwell_match) begin
              state_d = ST_CLEAR;
              retry_d = retry_sat;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as acqState.
  always_comb begin
    lead_d  = is_locked_state(state_d) ? narrowLeadExp : wideLeadExp;
    lag_d   = is_locked_state(state_d) ? narrowLagExp  : wideLagExp;
    sweep_d = (state_d == ST_SWEEP);
    clear_d = (state_d == ST_CLEAR);
    lock_d  = is_locked_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lead_q  <= wideLeadExp;
      lag_q   <= wideLagExp;
      sweep_q <= 1'b0;
      clear_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      lead_q  <= lead_d;
      lag_q   <= lag_d;
      sweep_q <= sweep_d;
      clear_q <= clear_d;
      lock_q  <= lock_d;
    end
  end

  assign leadExp     = lead_q;
  assign lagExp      = lag_q;
  assign sweepEnable = sweep_q;
  assign clearAccum  = clear_q;
  assign acqLock     = lock_q;
  assign acqState    = state_q;
  assign retryCount  = retry_q;

endmodule

// File: tb/tb_carrier_acq_sequencer.sv
// tb_carrier_acq_sequencer
// Directed scenarios plus randomized stimulus, every cycle compared against a
// rule-level reference model of the acquisition sequence.
module tb_carrier_acq_sequencer;

  localparam int CNT_W   = 16;
  localparam int RETRY_W = 8;

  localparam int S_IDLE = 0, S_CLEAR = 1, S_SWEEP = 2, S_PULLIN = 3,
                 S_TRACK = 4, S_HOLD = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, acqEnable, sampleEn, carrierLock;
  logic [4:0]         wideLeadExp, wideLagExp, narrowLeadExp, narrowLagExp;
  logic [CNT_W-1:0]   sweepTimeout, settleCount, holdTimeout;
  logic [4:0]         leadExp, lagExp;
  logic               sweepEnable, clearAccum, acqLock;
  logic [2:0]         acqState;
  logic [RETRY_W-1:0] retryCount;

  carrier_acq_sequencer #(
    .CNT_W   (CNT_W),
    .RETRY_W (RETRY_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .acqEnable     (acqEnable),
    .sampleEn      (sampleEn),
    .carrierLock   (carrierLock),
    .wideLeadExp   (wideLeadExp),
    .wideLagExp    (wideLagExp),
    .narrowLeadExp (narrowLeadExp),
    .narrowLagExp  (narrowLagExp),
    .sweepTimeout  (sweepTimeout),
    .settleCount   (settleCount),
    .holdTimeout   (holdTimeout),
    .leadExp       (leadExp),
    .lagExp        (lagExp),
    .sweepEnable   (sweepEnable),
    .clearAccum    (clearAccum),
    .acqLock       (acqLock),
    .acqState      (acqState),
    .retryCount    (retryCount)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_st    = S_IDLE;
  int m_retry = 0;
  int m_dwell = 0;
  int m_lead  = 0;
  int m_lag   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // One clock of the sequence rules, using the inputs present at the edge.
  task automatic model_step();
    int to;
    if (reset) begin
      m_st = S_IDLE; m_retry = 0; m_dwell = 0;
    end else if (!acqEnable) begin
      m_st = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE:  begin m_st = S_CLEAR; m_retry = 0; end
        S_CLEAR: begin m_st = S_SWEEP; m_dwell = 0; end
        S_SWEEP: if (sampleEn) begin
          to = int'(sweepTimeout);
          if (carrierLock) begin m_st = S_PULLIN; m_dwell = 0; end
          else if (to != 0 && m_dwell == to - 1) begin
            m_st = S_CLEAR; m_retry = sat_inc(m_retry, 255);
          end else m_dwell = sat_inc(m_dwell, 65535);
        end
        S_PULLIN: if (sampleEn) begin
          to = int'(settleCount);
          if (!carrierLock) begin m_st = S_SWEEP; m_dwell = 0; end
          else if (to == 0 || m_dwell >= to - 1) m_st = S_TRACK;
          else m_dwell = sat_inc(m_dwell, 65535);
        end
        S_TRACK: if (sampleEn && !carrierLock) begin
          m_st = S_HOLD; m_dwell = 0;
        end
        S_HOLD: if (sampleEn) begin
          to = int'(holdTimeout);
          if (carrierLock) m_st = S_TRACK;
          else if (to == 0 || m_dwell == to - 1) begin
            m_st = S_CLEAR; m_retry = sat_inc(m_retry, 255);
          end else m_dwell = sat_inc(m_dwell, 65535);
        end
        default: m_st = S_IDLE;
      endcase
    end
    if (m_st == S_TRACK || m_st == S_HOLD) begin
      m_lead = int'(narrowLeadExp); m_lag = int'(narrowLagExp);
    end else begin
      m_lead = int'(wideLeadExp);   m_lag = int'(wideLagExp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("acqState",    32'(acqState),    m_st);
    check_eq("retryCount",  32'(retryCount),  m_retry);
    check_eq("leadExp",     32'(leadExp),     m_lead);
    check_eq("lagExp",      32'(lagExp),      m_lag);
    check_eq("sweepEnable", 32'(sweepEnable), (m_st == S_SWEEP) ? 1 : 0);
    check_eq("clearAccum",  32'(clearAccum),  (m_st == S_CLEAR) ? 1 : 0);
    check_eq("acqLock",     32'(acqLock),     (m_st == S_TRACK || m_st == S_HOLD) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1; acqEnable = 1'b0; sampleEn = 1'b0; carrierLock = 1'b0;
    wideLeadExp = 5'h03; wideLagExp = 5'h07;
    narrowLeadExp = 5'h0C; narrowLagExp = 5'h11;
    sweepTimeout = 16'd4; settleCount = 16'd3; holdTimeout = 16'd5;
    #2;
    tick(); tick();
    check_eq("reset_state", 32'(acqState), S_IDLE);
    check_eq("reset_lead",  32'(leadExp), 32'h03);
    reset = 1'b0;
    tick();

    // Sweep timeouts: two restarts
    acqEnable = 1'b1; sampleEn = 1'b1; carrierLock = 1'b0;
    tick();
    check_eq("enable_clear_pulse", 32'(clearAccum), 1);
    tick();
    check_eq("clear_one_clk", 32'(clearAccum), 0);
    repeat (9) tick();
    check_eq("retry_two_timeouts", 32'(retryCount), 2);

    // Lock on the 3rd SWEEP sample, settle over 3 PULLIN samples
    tick();
    tick(); tick();
    carrierLock = 1'b1;
    tick();
    check_eq("pullin_entered", 32'(acqState), S_PULLIN);
    repeat (3) tick();
    check_eq("track_entered", 32'(acqState), S_TRACK);
    check_eq("track_narrow_lead", 32'(leadExp), 32'h0C);
    check_eq("track_narrow_lag",  32'(lagExp),  32'h11);

    // Short holdover then recovery, then a hold timeout
    carrierLock = 1'b0;
    tick(); tick();
    check_eq("holdover_lock", 32'(acqLock), 1);
    carrierLock = 1'b1;
    tick();
    check_eq("holdover_recover", 32'(acqState), S_TRACK);
    carrierLock = 1'b0;
    repeat (6) tick();
    check_eq("hold_timeout_clear", 32'(acqState), S_CLEAR);
    check_eq("hold_timeout_retry", 32'(retryCount), 3);

    // PULLIN loses lock on its 2nd sample
    tick();
    carrierLock = 1'b1;
    tick(); tick();
    carrierLock = 1'b0;
    tick();
    check_eq("pullin_drop_sweep", 32'(acqState), S_SWEEP);
    check_eq("pullin_drop_noclr", 32'(clearAccum), 0);

    // settleCount=0: TRACK on first locked PULLIN sample
    settleCount = 16'd0; carrierLock = 1'b1;
    tick(); tick();
    check_eq("settle0_track", 32'(acqState), S_TRACK);

    // Disable in HOLDOVER together with a sample, then re-enable
    carrierLock = 1'b0;
    tick();
    check_eq("hold_entered", 32'(acqState), S_HOLD);
    acqEnable = 1'b0;
    tick();
    check_eq("disable_idle", 32'(acqState), S_IDLE);
    check_eq("disable_nolock", 32'(acqLock), 0);
    acqEnable = 1'b1;
    tick();
    check_eq("reenable_clear", 32'(clearAccum), 1);
    check_eq("reenable_retry0", 32'(retryCount), 0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      acqEnable = ($urandom_range(0, 99) != 0);
      sampleEn  = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) < 15) carrierLock = ~carrierLock;
      if ($urandom_range(0, 49) == 0) begin
        sweepTimeout = 16'($urandom_range(0, 6));
        settleCount  = 16'($urandom_range(0, 6));
        holdTimeout  = 16'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 19) == 0) begin
        wideLeadExp   = 5'($urandom); wideLagExp   = 5'($urandom);
        narrowLeadExp = 5'($urandom); narrowLagExp = 5'($urandom);
      end
      tick();
    end

    // Unlimited sweep: no restart and the dwell counter saturates
    reset = 1'b1; acqEnable = 1'b1; sampleEn = 1'b1; carrierLock = 1'b0;
    sweepTimeout = 16'd0;
    tick();
    reset = 1'b0;
    repeat (70005) tick();
    check_eq("sweep0_state", 32'(acqState), S_SWEEP);
    check_eq("sweep0_retry", 32'(retryCount), 0);
    check_eq("sweep0_dwell_sat", 32'(dut.dwell_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
